// File: rtl/mem_stage.sv
// MEM stage: waits on data-SRAM responses, extracts load data,
// forwards results to ID/WB and drops responses orphaned by a flush.
module mem_stage #(
  parameter int EXC_W = 85
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   es2ms_valid,
  input  logic [109+EXC_W-1:0]   es2ms_bus,
  input  logic                   es_req_outstanding,
  output logic                   ms_allowin,
  input  logic                   ws_allowin,
  output logic                   ms2ws_valid,
  output logic [64+EXC_W-1:0]    ms2ws_bus,
  output logic [38:0]            ms_rf_zip,
  output logic [38:0]            ms_fwd_zip,
  output logic                   ms_ex,
  input  logic                   wb_flush,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata
);

  typedef struct packed {
    logic [31:0]      vaddr;
    logic [31:0]      pc;
    logic [EXC_W-1:0] exc;
    logic             has_exc;
    logic             mem_req;
    logic             res_from_mem;
    logic [2:0]       mem_op;
    logic             csr_re;
    logic             rf_we;
    logic [4:0]       waddr;
    logic [31:0]      alu_res;
  } es2ms_t;

  logic        ms_valid_q, ms_valid_d;
  es2ms_t      bus_q, bus_d;
  logic [1:0]  cancel_q, cancel_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_data_q, buf_data_d;

  logic        data_ok_eff;
  logic        ms_wait;
  logic        ms_ready_go;
  logic        handoff;
  logic [2:0]  cnt_sum;
  logic [31:0] rdata_sel;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  logic [31:0] wdata;

  assign data_ok_eff = data_sram_data_ok & (cancel_q == 2'd0);
  assign ms_wait     = ms_valid_q & bus_q.mem_req
                     & ~bus_q.has_exc & ~buf_valid_q;
  assign ms_ready_go = ~ms_wait | data_ok_eff;
  assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms2ws_valid = ms_valid_q & ms_ready_go;
  assign handoff     = ms2ws_valid & ws_allowin;

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (wb_flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es2ms_valid;
    end
    bus_d = bus_q;
    if (es2ms_valid & ms_allowin) begin
      bus_d = es2ms_t'(es2ms_bus);
    end
  end

  // Capture the response when WB stalls so SRAM data is not lost.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (wb_flush | handoff) begin
      buf_valid_d = 1'b0;
    end else if (data_ok_eff & ms_wait & ~ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
  end

  always_comb begin
    cnt_sum  = {1'b0, cancel_q};
    cancel_d = cancel_q;
    if (wb_flush) begin
      cnt_sum = {1'b0, cancel_q}
              + {2'b00, ms_wait & ~data_ok_eff}
              + {2'b00, es_req_outstanding};
      if (data_sram_data_ok & (cancel_q != 2'd0)) begin
        cnt_sum = cnt_sum - 3'd1;
      end
      cancel_d = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
    end else if (data_sram_data_ok & (cancel_q != 2'd0)) begin
      cancel_d = cancel_q - 2'd1;
    end
  end

  assign rdata_sel = buf_valid_q ? buf_data_q : data_sram_rdata;

  always_comb begin
    unique case (bus_q.vaddr[1:0])
      2'd0:    ld_b = rdata_sel[7:0];
      2'd1:    ld_b = rdata_sel[15:8];
      2'd2:    ld_b = rdata_sel[23:16];
      default: ld_b = rdata_sel[31:24];
    endcase
    ld_h = bus_q.vaddr[1] ? rdata_sel[31:16] : rdata_sel[15:0];
    case (bus_q.mem_op)
      3'd1:    ld_val = {{24{ld_b[7]}}, ld_b};
      3'd2:    ld_val = {24'd0, ld_b};
      3'd3:    ld_val = {{16{ld_h[15]}}, ld_h};
      3'd4:    ld_val = {16'd0, ld_h};
      default: ld_val = rdata_sel;
    endcase
  end

  assign wdata = bus_q.res_from_mem ? ld_val : bus_q.alu_res;

  assign ms2ws_bus = {bus_q.vaddr, bus_q.pc, bus_q.exc};
  assign ms_rf_zip = {bus_q.csr_re,
                      bus_q.rf_we & ~bus_q.has_exc,
                      bus_q.waddr, wdata};
  assign ms_fwd_zip = {ms_valid_q & (bus_q.res_from_mem | bus_q.csr_re)
                         & ~ms_ready_go,
                       ms_valid_q & bus_q.rf_we & ~bus_q.has_exc,
                       bus_q.waddr, wdata};
  assign ms_ex = ms_valid_q & bus_q.has_exc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      cancel_q    <= 2'd0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= 32'd0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      cancel_q    <= cancel_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end

endmodule
